// File: rtl/vx_cache_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vx_cache_flush_ctrl
//  Purpose  : Writeback flush sequencer for one writeback-mode cache bank.
//             Walks every (line, way) slot in order. Each slot with a non-zero
//             dirty mask is written to memory as one masked write, and its
//             dirty mask is cleared only after memory accepts the write.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_cache_flush_ctrl #(
    parameter  int LINES_PER_BANK = 64,
    parameter  int NUM_WAYS       = 2,
    parameter  int LINE_SIZE      = 16,
    parameter  int TAG_WIDTH      = 20,
    localparam int LINE_SEL_BITS  = $clog2(LINES_PER_BANK)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               flush_valid,
    output logic                               flush_ready,
    output logic                               flush_busy,
    output logic                               flush_done,
    output logic                               ds_req_valid,
    input  logic                               ds_req_ready,
    output logic                               ds_req_clear,
    output logic [LINE_SEL_BITS-1:0]           ds_line_sel,
    output logic [NUM_WAYS-1:0]                ds_way_sel,
    input  logic [LINE_SIZE*8-1:0]             ds_rsp_data,
    input  logic [LINE_SIZE-1:0]               ds_rsp_byteen,
    input  logic [TAG_WIDTH-1:0]               ds_rsp_tag,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [TAG_WIDTH+LINE_SEL_BITS-1:0] mem_req_addr,
    output logic [LINE_SIZE*8-1:0]             mem_req_data,
    output logic [LINE_SIZE-1:0]               mem_req_byteen
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD   = 3'd1;
    localparam logic [2:0] c_ST_CAP  = 3'd2;
    localparam logic [2:0] c_ST_SEND = 3'd3;
    localparam logic [2:0] c_ST_CLR  = 3'd4;
    localparam logic [2:0] c_ST_ADV  = 3'd5;
    localparam logic [2:0] c_ST_DONE = 3'd6;

    localparam int                       c_WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [LINE_SEL_BITS-1:0] c_LAST_LINE = LINE_SEL_BITS'(LINES_PER_BANK - 1);

    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;
    logic [LINE_SEL_BITS-1:0] r_line;
    logic                     w_last_way;
    logic [NUM_WAYS-1:0]      w_way_oh;
    logic [LINE_SIZE*8-1:0]   r_data;
    logic [LINE_SIZE-1:0]     r_byteen;
    logic [TAG_WIDTH-1:0]     r_tag;

    // Way counter exists only for associative banks; a direct-mapped bank
    // always addresses way 0.
    generate
        if (NUM_WAYS > 1) begin : g_way_cnt
            logic [c_WAY_BITS-1:0] r_way;

            // Way index: restarts in IDLE, steps once per slot in ADV.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_way <= '0;
                end else if (r_state == c_ST_IDLE) begin
                    r_way <= '0;
                end else if (r_state == c_ST_ADV) begin
                    r_way <= r_way + 1'b1;
                end
            end

            assign w_last_way = (r_way == c_WAY_BITS'(NUM_WAYS - 1));
            assign w_way_oh   = NUM_WAYS'(1) << r_way;
        end else begin : g_no_way_cnt
            assign w_last_way = 1'b1;
            assign w_way_oh   = NUM_WAYS'(1);
        end
    endgenerate

    // Line index: restarts in IDLE, steps when the way index wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_line <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_line <= '0;
        end else if ((r_state == c_ST_ADV) && w_last_way) begin
            r_line <= r_line + 1'b1;
        end
    end

    // Next-state selection for the walk sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (flush_valid)   w_state_nxt = c_ST_RD;
            c_ST_RD:   if (ds_req_ready)  w_state_nxt = c_ST_CAP;
            c_ST_CAP:  w_state_nxt = (|ds_rsp_byteen) ? c_ST_SEND : c_ST_ADV;
            c_ST_SEND: if (mem_req_ready) w_state_nxt = c_ST_CLR;
            c_ST_CLR:  if (ds_req_ready)  w_state_nxt = c_ST_ADV;
            c_ST_ADV:  w_state_nxt = (w_last_way && (r_line == c_LAST_LINE)) ? c_ST_DONE : c_ST_RD;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register; reset aborts any walk in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the slot contents the cycle after the read grant; they stay
    // frozen through SEND so the memory request is stable under back-pressure.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_byteen <= '0;
            r_tag    <= '0;
        end else if (r_state == c_ST_CAP) begin
            r_data   <= ds_rsp_data;
            r_byteen <= ds_rsp_byteen;
            r_tag    <= ds_rsp_tag;
        end
    end

    assign flush_ready    = (r_state == c_ST_IDLE);
    assign flush_busy     = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign flush_done     = (r_state == c_ST_DONE);

    assign ds_req_valid   = (r_state == c_ST_RD) || (r_state == c_ST_CLR);
    assign ds_req_clear   = (r_state == c_ST_CLR);
    assign ds_line_sel    = r_line;
    // Way select is only meaningful alongside a request; it reads as zero
    // otherwise so an idle controller presents an all-quiet data-store port.
    assign ds_way_sel     = ds_req_valid ? w_way_oh : '0;

    assign mem_req_valid  = (r_state == c_ST_SEND);
    assign mem_req_addr   = {r_tag, r_line};
    assign mem_req_data   = r_data;
    assign mem_req_byteen = r_byteen;

endmodule
`default_nettype wire

// File: tb/tb_vx_cache_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_cache_flush_ctrl
//  Purpose  : Self-checking bench for vx_cache_flush_ctrl. A behavioural data
//             store answers reads; an ordered list of expected slot reads,
//             writebacks and clears is derived from the store contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vx_cache_flush_ctrl;

    localparam int c_L  = 64;
    localparam int c_W  = 2;
    localparam int c_TW = 20;
    localparam int c_LB = 6;
    localparam int c_AW = c_TW + c_LB;
    localparam logic [183:0] c_RST_OUTS = {1'b1, 183'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- default-parameter instance ----
    logic          reset_n, flush_valid, flush_ready, flush_busy, flush_done;
    logic          ds_req_valid, ds_req_ready, ds_req_clear;
    logic [c_LB-1:0] ds_line_sel;
    logic [c_W-1:0]  ds_way_sel;
    logic [127:0]  ds_rsp_data;
    logic [15:0]   ds_rsp_byteen;
    logic [c_TW-1:0] ds_rsp_tag;
    logic          mem_req_valid, mem_req_ready;
    logic [c_AW-1:0] mem_req_addr;
    logic [127:0]  mem_req_data;
    logic [15:0]   mem_req_byteen;
    logic [183:0]  outs;

    assign outs = {flush_ready, flush_busy, flush_done, ds_req_valid, ds_req_clear, ds_line_sel,
                   ds_way_sel, mem_req_valid, mem_req_addr, mem_req_data, mem_req_byteen};

    vx_cache_flush_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .flush_valid(flush_valid), .flush_ready(flush_ready),
        .flush_busy(flush_busy), .flush_done(flush_done),
        .ds_req_valid(ds_req_valid), .ds_req_ready(ds_req_ready), .ds_req_clear(ds_req_clear),
        .ds_line_sel(ds_line_sel), .ds_way_sel(ds_way_sel),
        .ds_rsp_data(ds_rsp_data), .ds_rsp_byteen(ds_rsp_byteen), .ds_rsp_tag(ds_rsp_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen)
    );

    // ---- direct-mapped, 4-line instance ----
    logic          s_flush_valid, s_flush_ready, s_flush_busy, s_flush_done;
    logic          s_ds_req_valid, s_ds_req_clear, s_mem_req_valid;
    logic          s_ds_req_ready = 1'b1;
    logic          s_mem_req_ready = 1'b1;
    logic [1:0]    s_ds_line_sel;
    logic [0:0]    s_ds_way_sel;
    logic [127:0]  s_ds_rsp_data, s_mem_req_data;
    logic [15:0]   s_ds_rsp_byteen, s_mem_req_byteen;
    logic [c_TW-1:0] s_ds_rsp_tag;
    logic [21:0]   s_mem_req_addr;

    vx_cache_flush_ctrl #(.LINES_PER_BANK(4), .NUM_WAYS(1), .LINE_SIZE(16), .TAG_WIDTH(20)) dut_w1 (
        .clk(clk), .reset_n(reset_n),
        .flush_valid(s_flush_valid), .flush_ready(s_flush_ready),
        .flush_busy(s_flush_busy), .flush_done(s_flush_done),
        .ds_req_valid(s_ds_req_valid), .ds_req_ready(s_ds_req_ready), .ds_req_clear(s_ds_req_clear),
        .ds_line_sel(s_ds_line_sel), .ds_way_sel(s_ds_way_sel),
        .ds_rsp_data(s_ds_rsp_data), .ds_rsp_byteen(s_ds_rsp_byteen), .ds_rsp_tag(s_ds_rsp_tag),
        .mem_req_valid(s_mem_req_valid), .mem_req_ready(s_mem_req_ready),
        .mem_req_addr(s_mem_req_addr), .mem_req_data(s_mem_req_data), .mem_req_byteen(s_mem_req_byteen)
    );

    // ---- reference data store and expected transaction list ----
    typedef struct {
        int              kind;   // 0 read, 1 writeback, 2 clear
        int              line;
        int              way;
        logic [c_AW-1:0] addr;
        logic [127:0]    data;
        logic [15:0]     be;
    } ev_t;

    typedef struct {
        int pattern;     // 0 clean, 1 single (5,1), 2 every 8th slot, 3 all dirty, 4 random
        int ds_pct;
        int mem_pct;
        int exp_writes;  // -1: take from store contents
        int exp_cycles;  // -1: not checked (random back-pressure)
        int hold_fv;     // keep flush_valid high during the walk
    } vec_t;

    logic [127:0]    m_data [c_L][c_W];
    logic [15:0]     m_be   [c_L][c_W];
    logic [c_TW-1:0] m_tag  [c_L][c_W];
    ev_t             exp_q[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, accept_cyc, done_cyc, done_seen, n_writes, n_accepts, n_mem_stall;
    int ds_pct = 100, mem_pct = 100, mem_hold = 0;
    logic [c_AW-1:0] last_wr_addr;
    logic [15:0]     last_wr_be;
    int              last_clr_line;
    logic [c_W-1:0]  last_clr_wsel;
    logic            p_ds_stall = 1'b0, p_mem_stall = 1'b0;
    logic [255:0]    p_ds_snap, p_mem_snap;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill(input int pattern);
        for (int l = 0; l < c_L; l++) begin
            for (int w = 0; w < c_W; w++) begin
                m_data[l][w] = {$urandom, $urandom, $urandom, $urandom};
                m_tag[l][w]  = 20'($urandom);
                case (pattern)
                    1:       m_be[l][w] = (l == 5 && w == 1) ? 16'h00F0 : 16'h0;
                    2:       m_be[l][w] = (((l * 2 + w) % 8) == 3) ? 16'($urandom_range(65535, 1)) : 16'h0;
                    3:       m_be[l][w] = 16'($urandom_range(65535, 1));
                    4:       m_be[l][w] = ($urandom_range(3) == 0) ? 16'($urandom_range(65535, 1)) : 16'h0;
                    default: m_be[l][w] = 16'h0;
                endcase
                if (pattern == 1 && l == 5 && w == 1) m_tag[l][w] = 20'hABCDE;
            end
        end
    endtask

    task automatic build_queue();
        ev_t e;
        exp_q.delete();
        for (int l = 0; l < c_L; l++) begin
            for (int w = 0; w < c_W; w++) begin
                e.line = l; e.way = w; e.addr = {m_tag[l][w], 6'(l)};
                e.data = m_data[l][w]; e.be = m_be[l][w];
                e.kind = 0; exp_q.push_back(e);
                if (m_be[l][w] != 16'h0) begin
                    e.kind = 1; exp_q.push_back(e);
                    e.kind = 2; exp_q.push_back(e);
                end
            end
        end
    endtask

    // One clock of the default instance: pick readies, check what the DUT
    // presents against the expected list, then answer an accepted read.
    task automatic run_cycle();
        ev_t  e;
        logic rd_acc;
        int   rl, rw;
        rd_acc = 1'b0; rl = 0; rw = 0;
        ds_req_ready = ($urandom_range(99) < ds_pct);
        if (mem_hold > 0 && mem_req_valid) begin
            mem_req_ready = 1'b0;
            mem_hold--;
        end else begin
            mem_req_ready = ($urandom_range(99) < mem_pct);
        end
        if (reset_n) begin
            if (p_ds_stall) chk("ds_stall_hold", {ds_req_valid, ds_req_clear, ds_line_sel, ds_way_sel}, p_ds_snap);
            if (p_mem_stall) begin
                n_mem_stall++;
                chk("mem_stall_hold", {mem_req_valid, mem_req_addr, mem_req_data, mem_req_byteen}, p_mem_snap);
            end
            if (ds_req_valid || mem_req_valid) chk("one_req_at_a_time", ds_req_valid && mem_req_valid, 1'b0);
            if (flush_done) begin done_seen++; done_cyc = cyc; end
            if (flush_valid && flush_ready) begin n_accepts++; accept_cyc = cyc; build_queue(); end
            if (ds_req_valid && ds_req_ready) begin
                chk("ds_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ds_kind_clear", ds_req_clear, e.kind == 2);
                    chk("ds_line", ds_line_sel, e.line);
                    chk("ds_way_sel", ds_way_sel, 2'b01 << e.way);
                end
                rl = int'(ds_line_sel); rw = ds_way_sel[1] ? 1 : 0;
                if (ds_req_clear) begin
                    m_be[rl][rw] = 16'h0;
                    last_clr_line = rl; last_clr_wsel = ds_way_sel;
                end else begin
                    rd_acc = 1'b1;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                n_writes++;
                last_wr_addr = mem_req_addr; last_wr_be = mem_req_byteen;
                chk("mem_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("mem_is_writeback", e.kind, 1);
                    chk("mem_addr", mem_req_addr, e.addr);
                    chk("mem_data", mem_req_data, e.data);
                    chk("mem_byteen", mem_req_byteen, e.be);
                end
            end
        end
        p_ds_stall  = reset_n && ds_req_valid && !ds_req_ready;
        p_ds_snap   = {ds_req_valid, ds_req_clear, ds_line_sel, ds_way_sel};
        p_mem_stall = reset_n && mem_req_valid && !mem_req_ready;
        p_mem_snap  = {mem_req_valid, mem_req_addr, mem_req_data, mem_req_byteen};
        @(posedge clk);
        #1;
        if (rd_acc) begin
            ds_rsp_data = m_data[rl][rw]; ds_rsp_byteen = m_be[rl][rw]; ds_rsp_tag = m_tag[rl][rw];
        end else begin
            ds_rsp_data = {$urandom, $urandom, $urandom, $urandom};
            ds_rsp_byteen = 16'($urandom); ds_rsp_tag = 20'($urandom);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_walk(input vec_t v);
        int expw;
        expw = 0;
        for (int l = 0; l < c_L; l++) for (int w = 0; w < c_W; w++) if (m_be[l][w] != 0) expw++;
        if (v.exp_writes >= 0) expw = v.exp_writes;
        ds_pct = v.ds_pct; mem_pct = v.mem_pct;
        done_seen = 0; n_writes = 0; n_accepts = 0; accept_cyc = -1; n_mem_stall = 0;
        flush_valid = 1'b1;
        for (int i = 0; i < 5 && accept_cyc < 0; i++) run_cycle();
        flush_valid = (v.hold_fv != 0);
        chk("flush_accepted", accept_cyc >= 0, 1'b1);
        chk("busy_after_accept", flush_busy, 1'b1);
        for (int i = 0; i < 4000 && done_seen == 0; i++) begin
            if (i == 50) flush_valid = 1'b0;
            run_cycle();
        end
        flush_valid = 1'b0;
        chk("done_pulse_seen", done_seen, 1);
        chk("all_expected_seen", exp_q.size(), 0);
        chk("writeback_count", n_writes, expw);
        chk("single_accept", n_accepts, 1);
        if (v.exp_cycles > 0) chk("walk_cycles", done_cyc - accept_cyc + 1, v.exp_cycles);
        run_cycle();
        run_cycle();
        chk("idle_after_done", {flush_ready, flush_busy, flush_done}, 3'b100);
        chk("single_done_pulse", done_seen, 1);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, 100, 100,   0, 386, 0};
        vecs[1] = '{1, 100, 100,   1, 388, 0};
        vecs[2] = '{2, 100, 100,  16, 418, 0};
        vecs[3] = '{3, 100, 100, 128, 642, 0};
        vecs[4] = '{4,  60,  70,  -1,  -1, 1};
        vecs[5] = '{1,  50, 100,   1,  -1, 0};

        reset_n = 1'b0; flush_valid = 1'b1; ds_req_ready = 1'b1; mem_req_ready = 1'b1;
        ds_rsp_data = '0; ds_rsp_byteen = '0; ds_rsp_tag = '0;
        s_flush_valid = 1'b0; s_ds_rsp_data = '0; s_ds_rsp_byteen = '0; s_ds_rsp_tag = '0;
        fill(0);

        // Reset held with a flush request pending: nothing starts.
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            chk("reset_outputs", outs, c_RST_OUTS);
        end
        reset_n = 1'b1;
        accept_cyc = -1; n_accepts = 0; done_seen = 0;
        run_cycle();
        chk("accept_right_after_reset", accept_cyc, cyc - 1);
        chk("busy_after_reset_release", flush_busy, 1'b1);
        flush_valid = 1'b0;
        reset_n = 1'b0;
        run_cycle();
        exp_q.delete();
        reset_n = 1'b1;

        // Table-driven walks.
        for (int k = 0; k < 6; k++) begin
            fill(vecs[k].pattern);
            run_walk(vecs[k]);
            if (vecs[k].pattern == 1) begin
                chk("single_wr_addr", last_wr_addr, {20'hABCDE, 6'd5});
                chk("single_wr_be", last_wr_be, 16'h00F0);
                chk("single_clr_line", last_clr_line, 5);
                chk("single_clr_way_sel", last_clr_wsel, 2'b10);
            end
        end

        // Memory stalls a dirty slot for 10 cycles.
        fill(1);
        mem_hold = 10;
        run_walk('{1, 100, 100, 1, 398, 0});
        chk("mem_stall_cycles", n_mem_stall, 10);

        // Reset in the middle of a walk.
        fill(4);
        ds_pct = 80; mem_pct = 80; done_seen = 0; accept_cyc = -1;
        flush_valid = 1'b1;
        for (int i = 0; i < 5 && accept_cyc < 0; i++) run_cycle();
        flush_valid = 1'b0;
        for (int i = 0; i < 3000 && ds_line_sel != 6'd20; i++) run_cycle();
        chk("reached_line_20", ds_line_sel, 6'd20);
        reset_n = 1'b0;
        run_cycle();
        chk("abort_reset_outputs", outs, c_RST_OUTS);
        run_cycle();
        exp_q.delete();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) run_cycle();
        chk("no_done_after_abort", done_seen, 0);
        chk("idle_after_abort", {flush_ready, flush_busy}, 2'b10);
        run_walk('{4, 70, 70, -1, -1, 0});

        // Direct-mapped 4-line bank, every slot dirty.
        begin
            logic [127:0]    s_data [4];
            logic [15:0]     s_be   [4];
            logic [c_TW-1:0] s_tag  [4];
            int s_acc, s_done, rd_i, wr_i, clr_i, s_rl;
            logic s_rd;
            for (int i = 0; i < 4; i++) begin
                s_data[i] = {$urandom, $urandom, $urandom, $urandom};
                s_be[i]   = 16'($urandom_range(65535, 1));
                s_tag[i]  = 20'($urandom);
            end
            s_acc = -1; s_done = -1; rd_i = 0; wr_i = 0; clr_i = 0; s_rl = 0;
            s_flush_valid = 1'b1;
            for (int c = 0; c < 100 && s_done < 0; c++) begin
                s_rd = 1'b0;
                if (s_flush_valid && s_flush_ready) s_acc = c;
                if (s_ds_req_valid) chk("w1_way_sel", s_ds_way_sel, 1'b1);
                if (s_ds_req_valid && !s_ds_req_clear) begin
                    chk("w1_rd_line", s_ds_line_sel, rd_i);
                    rd_i++; s_rd = 1'b1; s_rl = int'(s_ds_line_sel);
                end
                if (s_ds_req_valid && s_ds_req_clear) begin
                    chk("w1_clr_line", s_ds_line_sel, clr_i);
                    chk("w1_clr_after_wr", clr_i < wr_i, 1'b1);
                    clr_i++;
                end
                if (s_mem_req_valid) begin
                    chk("w1_wr_in_range", wr_i < 4, 1'b1);
                    if (wr_i < 4) begin
                        chk("w1_wr_addr", s_mem_req_addr, {s_tag[wr_i], 2'(wr_i)});
                        chk("w1_wr_data", s_mem_req_data, s_data[wr_i]);
                        chk("w1_wr_be", s_mem_req_byteen, s_be[wr_i]);
                    end
                    wr_i++;
                end
                if (s_flush_done) s_done = c;
                @(posedge clk);
                #1;
                if (s_acc >= 0) s_flush_valid = 1'b0;
                if (s_rd) begin
                    s_ds_rsp_data = s_data[s_rl]; s_ds_rsp_byteen = s_be[s_rl]; s_ds_rsp_tag = s_tag[s_rl];
                end else begin
                    s_ds_rsp_data = '0; s_ds_rsp_byteen = 16'($urandom); s_ds_rsp_tag = '0;
                end
                @(negedge clk);
            end
            chk("w1_done_seen", s_done >= 0, 1'b1);
            chk("w1_writes", wr_i, 4);
            chk("w1_clears", clr_i, 4);
            chk("w1_walk_cycles", s_done - s_acc + 1, 22);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
